// File: rtl/fetch_ctrl_if.sv
// Instruction-memory request/acknowledge bus between the fetch controller
// (master) and the instruction memory (slave).
interface fetch_ctrl_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ack_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ack_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single-outstanding imem requests, a registered
// IF/ID slot with a 1-entry skid buffer, and redirect handling with drop of stale data.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  fetch_ctrl_if.master       imem,
  output logic               if_valid_o,
  output logic [31:0]        if_pc_o,
  output logic [31:0]        if_instr_o,
  output logic               misalign_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD, DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        slot_valid_q, slot_valid_d;
  logic [31:0] slot_pc_q, slot_pc_d;
  logic [31:0] slot_instr_q, slot_instr_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic        misalign_q, misalign_d;

  logic        req_active;
  logic        fetch_ack;
  logic [31:0] target_pc;

  assign req_active = (state_q == REQ) || (state_q == DROP);
  assign fetch_ack  = imem.imem_ack_i && req_active;
  assign target_pc  = {redirect_pc_i[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_VEC;
      pending_q    <= 32'h0;
      slot_valid_q <= 1'b0;
      slot_pc_q    <= 32'h0;
      slot_instr_q <= 32'h0;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= 32'h0;
      skid_instr_q <= 32'h0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      slot_valid_q <= slot_valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_instr_q <= slot_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
      misalign_q   <= misalign_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    slot_valid_d = slot_valid_q;
    slot_pc_d    = slot_pc_q;
    slot_instr_d = slot_instr_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;
    misalign_d   = redirect_i && (redirect_pc_i[1:0] != 2'b00);

    if (redirect_i) begin
      slot_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      // An unacked request must complete before the new target may be issued;
      // a redirect that coincides with the ack can go straight to the target.
      if (req_active && !fetch_ack) begin
        pending_d = target_pc;
        state_d   = DROP;
      end else begin
        pc_d    = target_pc;
        state_d = REQ;
      end
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (fetch_ack) begin
            pc_d = pc_q + 32'd4;
            if (!slot_valid_q || !stall_i) begin
              slot_valid_d = 1'b1;
              slot_pc_d    = pc_q;
              slot_instr_d = imem.imem_rdata_i;
            end else begin
              skid_valid_d = 1'b1;
              skid_pc_d    = pc_q;
              skid_instr_d = imem.imem_rdata_i;
              state_d      = HOLD;
            end
          end else if (!stall_i) begin
            slot_valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall_i) begin
            slot_valid_d = skid_valid_q;
            slot_pc_d    = skid_pc_q;
            slot_instr_d = skid_instr_q;
            skid_valid_d = 1'b0;
            state_d      = REQ;
          end
        end
        DROP: begin
          if (fetch_ack) begin
            pc_d    = pending_q;
            state_d = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    imem.imem_req_o  = req_active;
    imem.imem_addr_o = pc_q;
    if_valid_o       = slot_valid_q;
    if_pc_o          = slot_pc_q;
    if_instr_o       = slot_instr_q;
    misalign_o       = misalign_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then randomized traffic,
// compared every cycle against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_VEC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic [31:0] if_pc_o;
  logic [31:0] if_instr_o;
  logic        misalign_o;

  fetch_ctrl_if imem_bus ();

  fetch_ctrl #(.RESET_VEC(RESET_VEC)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem          (imem_bus),
    .if_valid_o    (if_valid_o),
    .if_pc_o       (if_pc_o),
    .if_instr_o    (if_instr_o),
    .misalign_o    (misalign_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: delivered-but-unconsumed instructions live in a queue
  // (front = IF/ID slot, second entry = skid); memory returns addr ^ all-ones.
  bit          m_idle;
  bit          m_drop;
  bit          m_mis;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];

  function automatic bit modelReq();
    return !m_idle && (q_pc.size() < 2);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic modelStep(input bit r, input bit st, input bit rd, input logic [31:0] tgt, input bit ack);
    bit          req_now;
    bit          ack_eff;
    logic [31:0] al;
    al = {tgt[31:2], 2'b00};
    if (r) begin
      m_idle = 1'b1;
      m_drop = 1'b0;
      m_mis  = 1'b0;
      m_pc   = RESET_VEC;
      m_pend = 32'h0;
      q_pc.delete();
      q_instr.delete();
    end else begin
      m_mis   = rd && (tgt[1:0] != 2'b00);
      req_now = modelReq();
      ack_eff = ack && req_now;
      if (rd) begin
        q_pc.delete();
        q_instr.delete();
        if (req_now && !ack_eff) begin
          m_drop = 1'b1;
          m_pend = al;
        end else begin
          m_drop = 1'b0;
          m_pc   = al;
        end
        m_idle = 1'b0;
      end else if (m_idle) begin
        m_idle = 1'b0;
      end else if (m_drop) begin
        if (ack_eff) begin
          m_drop = 1'b0;
          m_pc   = m_pend;
        end
      end else begin
        if (!st && q_pc.size() > 0) begin
          void'(q_pc.pop_front());
          void'(q_instr.pop_front());
        end
        if (ack_eff) begin
          q_pc.push_back(m_pc);
          q_instr.push_back(m_pc ^ 32'hFFFF_FFFF);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  task automatic compareAll();
    bit exp_req;
    exp_req = modelReq();
    checkOutput("imem_req", {31'd0, imem_bus.imem_req_o}, {31'd0, exp_req});
    if (exp_req) checkOutput("imem_addr", imem_bus.imem_addr_o, m_pc);
    checkOutput("if_valid", {31'd0, if_valid_o}, {31'd0, (q_pc.size() > 0)});
    if (q_pc.size() > 0) begin
      checkOutput("if_pc", if_pc_o, q_pc[0]);
      checkOutput("if_instr", if_instr_o, q_instr[0]);
    end
    checkOutput("misalign", {31'd0, misalign_o}, {31'd0, m_mis});
  endtask

  // One clock cycle: drive inputs at the falling edge, advance model, sample at next falling edge.
  task automatic applyStimulus(input bit r, input bit st, input bit rd, input logic [31:0] tgt, input bit ack);
    rst                   = r;
    stall_i               = st;
    redirect_i            = rd;
    redirect_pc_i         = tgt;
    imem_bus.imem_ack_i   = ack;
    imem_bus.imem_rdata_i = ack ? (imem_bus.imem_addr_o ^ 32'hFFFF_FFFF) : $urandom;
    modelStep(r, st, rd, tgt, ack);
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit          r, st, rd, ack;
    logic [31:0] tgt;

    rst = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;
    imem_bus.imem_ack_i = 1'b0; imem_bus.imem_rdata_i = 32'h0;
    @(negedge clk);

    // Reset values, then the one IDLE cycle, then 0-wait streaming
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 1, 32'h0000_0080, 1);
    checkOutput("rst_valid", {31'd0, if_valid_o}, 32'd0);
    checkOutput("rst_pc", if_pc_o, 32'd0);
    checkOutput("rst_instr", if_instr_o, 32'd0);
    checkOutput("rst_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("first_addr", imem_bus.imem_addr_o, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("stream_pc0", if_pc_o, 32'h0);
    checkOutput("stream_addr4", imem_bus.imem_addr_o, 32'h4);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("stream_pc4", if_pc_o, 32'h4);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("stream_pc8", if_pc_o, 32'h8);
    checkOutput("stream_valid", {31'd0, if_valid_o}, 32'd1);

    // Stall with full slot pushes the ack into the skid and parks in HOLD
    applyStimulus(0, 0, 1, 32'h10, 1);
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 1, 0, 32'h0, 1);
    checkOutput("hold_req", {31'd0, imem_bus.imem_req_o}, 32'd0);
    applyStimulus(0, 1, 0, 32'h0, 0);
    applyStimulus(0, 1, 0, 32'h0, 0);
    checkOutput("hold_pc", if_pc_o, 32'h10);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("skid_pc", if_pc_o, 32'h14);
    checkOutput("skid_instr", if_instr_o, 32'h14 ^ 32'hFFFF_FFFF);
    checkOutput("after_hold_addr", imem_bus.imem_addr_o, 32'h18);

    // Redirect while a request waits: old address held, its data dropped
    applyStimulus(0, 0, 1, 32'h20, 1);
    applyStimulus(0, 0, 1, 32'h100, 0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 32'h0, 0);
      checkOutput("drop_addr", imem_bus.imem_addr_o, 32'h20);
    end
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("drop_next_addr", imem_bus.imem_addr_o, 32'h100);
    checkOutput("drop_valid", {31'd0, if_valid_o}, 32'd0);

    // Redirect together with stall while the skid is occupied
    applyStimulus(0, 0, 0, 32'h0, 1);
    applyStimulus(0, 1, 0, 32'h0, 1);
    applyStimulus(0, 1, 1, 32'h300, 0);
    checkOutput("flush_valid", {31'd0, if_valid_o}, 32'd0);
    checkOutput("flush_addr", imem_bus.imem_addr_o, 32'h300);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("flush_pc", if_pc_o, 32'h300);

    // Misaligned target
    applyStimulus(0, 0, 1, 32'h203, 1);
    checkOutput("misalign_pulse", {31'd0, misalign_o}, 32'd1);
    checkOutput("misalign_addr", imem_bus.imem_addr_o, 32'h200);
    applyStimulus(0, 0, 0, 32'h0, 0);
    checkOutput("misalign_clear", {31'd0, misalign_o}, 32'd0);

    // Reset during DROP with a late ack
    applyStimulus(0, 0, 1, 32'h400, 0);
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(1, 0, 0, 32'h0, 1);
    applyStimulus(1, 0, 0, 32'h0, 0);
    applyStimulus(0, 0, 0, 32'h0, 1);
    checkOutput("rst_idle_req", {31'd0, imem_bus.imem_req_o}, 32'd1);
    checkOutput("rst_restart_addr", imem_bus.imem_addr_o, RESET_VEC);
    checkOutput("rst_restart_valid", {31'd0, if_valid_o}, 32'd0);

    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      st  = ($urandom_range(0, 9) < 4);
      rd  = ($urandom_range(0, 15) == 0);
      tgt = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'h0000_000F);
      ack = modelReq() ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 9) == 0);
      applyStimulus(r, st, rd, tgt, ack);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000, SHALL be the PC loaded on reset.
REQ-002 clk  input  1  SHALL be the clock; all state SHALL update on the rising edge only.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 stall_i  input  1  SHALL be the hazard-unit stall; when 1, the IF/ID output is not consumed this cycle.
REQ-005 redirect_i  input  1  SHALL indicate a taken branch or jump from EX.
REQ-006 redirect_pc_i  input  32  SHALL be the branch/jump target.
REQ-007 imem_req_o  output  1  SHALL be the instruction-memory request.
REQ-008 imem_addr_o  output  32  SHALL be the fetch address.
REQ-009 imem_ack_i  input  1  SHALL be the memory acknowledge, 0 or more cycles after the request.
REQ-010 imem_rdata_i  input  32  SHALL be the instruction, valid with imem_ack_i.
REQ-011 if_valid_o, if_pc_o[31:0], if_instr_o[31:0]  output  SHALL be the registered IF/ID slot.
REQ-012 misalign_o  output  1  SHALL pulse 1 cycle when a redirect target has bits [1:0] != 0.

Function
REQ-013 FSM states SHALL be IDLE, REQ, HOLD and DROP; the encoding is free.
REQ-014 IDLE SHALL last exactly 1 cycle after reset, with imem_req_o=0, then go to REQ.
REQ-015 In REQ and DROP, imem_req_o SHALL be 1 and imem_addr_o SHALL equal the internal fetch PC (pc_q).
REQ-016 In IDLE and HOLD, imem_req_o SHALL be 0.
REQ-017 At most one request SHALL be outstanding.
REQ-018 While imem_req_o=1 and before imem_ack_i, imem_addr_o SHALL stay stable.
REQ-019 REQ with ack and slot free (!if_valid_o || !stall_i): next cycle if_valid_o=1, if_pc_o=pc_q, if_instr_o=imem_rdata_i; pc_q<=pc_q+4 (mod 2^32); state stays REQ.
REQ-020 REQ with ack and slot busy (if_valid_o && stall_i): rdata and pc_q SHALL go to a 1-entry skid buffer; pc_q<=pc_q+4; state goes to HOLD.
REQ-021 HOLD while stall_i=1: the slot and the skid buffer SHALL be held unchanged.
REQ-022 HOLD with stall_i=0: the skid SHALL move into the slot next cycle and the state SHALL go to REQ.
REQ-023 When no new fetch data arrives and stall_i=0, if_valid_o SHALL clear next cycle.
REQ-024 When stall_i=1 and no flush occurs, the slot SHALL hold its value.
REQ-025 redirect_i SHALL have highest priority, over stall_i, ack and the skid.
REQ-026 On redirect, next cycle: if_valid_o=0, skid discarded, pc_q<={redirect_pc_i[31:2],2'b00}.
REQ-027 Redirect with the request unacked (REQ without ack): state SHALL go to DROP, keeping the old address and the request.
REQ-028 Redirect while in REQ with ack, in HOLD, or in IDLE: state SHALL go to REQ at the new pc_q.
REQ-029 In DROP, the new target SHALL be held in a pending register.
REQ-030 DROP on ack: data SHALL be discarded, pc_q<=pending, state goes to REQ.
REQ-031 A further redirect in DROP SHALL overwrite pending and the state SHALL stay in DROP.
REQ-032 misalign_o SHALL be 1 in the cycle after a redirect with redirect_pc_i[1:0]!=0, else 0; the fetch proceeds at the aligned address.
REQ-033 ack with imem_req_o=0 SHALL be ignored.
REQ-034 The fetched instruction stream SHALL have no duplicate, skipped or reordered instruction outside redirects.

Reset
REQ-035 rst=1 SHALL force: state IDLE, pc_q=RESET_VEC, if_valid_o=0, if_pc_o=0, if_instr_o=0, imem_req_o=0, misalign_o=0, skid empty, pending=0.
REQ-036 Reset SHALL take priority over every other input, including mid-request.
REQ-037 A late ack from a request cut off by reset SHALL be ignored.

Verification
REQ-038 Reset release, 0-wait memory returning addr^32'hFFFF_FFFF: req at 0x0, 0x4, 0x8 on consecutive cycles; if_valid_o stays 1; if_pc_o = 0,4,8.
REQ-039 Ack in REQ with stall_i=1 for 3 cycles and slot full: state goes to HOLD, req=0; on stall release the skid enters the slot; no loss or duplicate across pc 0x10, 0x14.
REQ-040 Redirect to 0x100 while the request at 0x20 waits 4 cycles for ack: req held at 0x20; its data is dropped; next request is at 0x100; if_valid_o=0 throughout.
REQ-041 redirect_i and stall_i together with a skid held: next cycle if_valid_o=0, skid empty, request at the target.
REQ-042 Redirect to 0x203: misalign_o pulses 1 cycle; fetch at 0x200.
REQ-043 rst asserted during DROP, with ack 2 cycles later: the ack is ignored; fetch restarts at RESET_VEC after IDLE.
